lin_to_lns: RTL

- Encoder that converts signed two's-complement fixed-point linear values into the 12-bit LNS word consumed by the LNS adder/multiplier datapath.
- The word is {sign, 11-bit two's-complement log2 magnitude in Q4.7}.
- The block sits at the datapath ingress.
- It is iterative: one leading-one normalisation cycle, then 7 squaring cycles, one fractional log bit per cycle.
- Input and output use valid/ready handshakes.

---
 rtl/lin_to_lns.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lin_to_lns.sv
// Iterative linear-to-LNS encoder: signed Q8.8 in, {sign, Q4.7 log2|x|} out.
// One leading-one normalisation cycle, seven squaring cycles, one result-register cycle.
module lin_to_lns #(
  parameter int IN_W    = 16,
  parameter int IN_FRAC = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     out_lns
);

  typedef enum logic [1:0] {IDLE, NORM, FRAC, DONE} state_t;

  state_t state, state_next;

  logic            sign;
  logic [15:0]     mag;
  logic [15:0]     m;
  logic [3:0]      e;
  logic [6:0]      frac;
  logic [2:0]      cnt;
  logic            zero_flag;
  logic            valid_q;
  logic [11:0]     lns_q;

  logic [15:0]     mag_in;
  logic [3:0]      lead;
  logic [16:0]     sq_hi;
  logic [15:0]     m_next;
  logic [10:0]     log_raw;
  logic [11:0]     result;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = NORM;
      NORM: state_next = FRAC;
      FRAC: if (cnt == 3'd6) state_next = DONE;
      DONE: if (valid_q && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = valid_q;
    out_lns   = lns_q;
  end

  // Datapath helpers
  always_comb begin
    mag_in = in_data[15] ? (~in_data + 16'd1) : in_data;
    lead = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (mag[i]) lead = 4'(i);
    end
  end

  // Only bits [31:15] of the 2.30 square matter: bit 31 is the log bit,
  // the rest is the renormalised 1.15 mantissa.
  always_comb begin
    sq_hi   = 17'((32'(m) * 32'(m)) >> 15);
    m_next  = sq_hi[16] ? sq_hi[16:1] : sq_hi[15:0];
    // e*128 + frac is just the concatenation since frac is 7 bits
    log_raw = {e, frac};
    if (zero_flag)               result = 12'h400;
    else if (log_raw == 11'h400) result = {sign, 11'h401};
    else                         result = {sign, log_raw};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sign      <= 1'b0;
      mag       <= '0;
      m         <= '0;
      e         <= '0;
      frac      <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
      valid_q   <= 1'b0;
      lns_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_data[15];
            mag  <= mag_in;
          end
        end
        NORM: begin
          e         <= 4'(lead - 4'(IN_FRAC));
          m         <= mag << (4'd15 - lead);
          zero_flag <= (mag == 16'd0);
          frac      <= '0;
          cnt       <= '0;
        end
        FRAC: begin
          frac <= {frac[5:0], sq_hi[16]};
          m    <= m_next;
          cnt  <= cnt + 3'd1;
        end
        DONE: begin
          if (!valid_q) begin
            lns_q   <= result;
            valid_q <= 1'b1;
          end else if (out_ready) begin
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
